// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 timing constants, totals and the
// bundle of raw sync/enable signals carried down the alignment pipe.
package vga_timing_pkg;

  localparam int CW = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int h_total(
    input int act,
    input int fp,
    input int sw,
    input int bp
  );
    return act + fp + sw + bp;
  endfunction

  function automatic int v_total(
    input int act,
    input int fp,
    input int sw,
    input int bp
  );
    return act + fp + sw + bp;
  endfunction

  // hs/vs hold the physical pin level (polarity already applied)
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic ls;
    logic fs;
  } tim_t;

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: W-bit shift register of DEPTH stages, every tap cleared
// to rst_val on synchronous rst; DEPTH=0 is a wire. Ports: clk, rst, din, rst_val, dout.
module vga_delay_line #(
  parameter int W     = 5,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic [W-1:0] rst_val,
  output logic [W-1:0] dout
);

  if (DEPTH == 0) begin : g_pass

    assign dout = din;

  end else begin : g_shift

    logic [W-1:0] tap_q [DEPTH];
    logic [W-1:0] tap_d [DEPTH];

    always_comb begin
      tap_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        tap_d[i] = tap_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          tap_q[i] <= rst_val;
        end
      end else begin
        tap_q <= tap_d;
      end
    end

    assign dout = tap_q[DEPTH-1];

  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing from the pixel clock; pixel requests lead
// de/hsync/vsync/line_start/frame_start by PIPE_DLY cycles. Ports: clk, rst, pll_locked, req_*, syncs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   PIPE_DLY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pll_locked,
  output logic          req_valid,
  output logic [CW-1:0] req_x,
  output logic [CW-1:0] req_y,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  localparam tim_t TIM_IDLE = '{
    hs: ~HS_POL,
    vs: ~VS_POL,
    de: 1'b0,
    ls: 1'b0,
    fs: 1'b0
  };

  logic          lock_meta_q, lock_meta_d;
  logic          run_q, run_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;

  logic          req_valid_q, req_valid_d;
  logic [CW-1:0] req_x_q, req_x_d;
  logic [CW-1:0] req_y_q, req_y_d;
  tim_t          raw_q, raw_d;
  tim_t          tim_out;

  logic          h_vis, v_vis;
  logic          hs_on, vs_on;
  logic          h_zero, v_zero;

  // lock synchroniser and raster counters; idle run holds (0,0)
  always_comb begin
    lock_meta_d = pll_locked;
    run_d       = lock_meta_q;
    hcnt_d      = '0;
    vcnt_d      = '0;
    if (run_q) begin
      if (hcnt_q == H_LAST) begin
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CW'(1);
      end else begin
        hcnt_d = hcnt_q + CW'(1);
        vcnt_d = vcnt_q;
      end
    end
  end

  // stage 0: request and raw timing decoded from the same counter state
  always_comb begin
    h_vis  = hcnt_q < H_VIS;
    v_vis  = vcnt_q < V_VIS;
    h_zero = hcnt_q == '0;
    v_zero = vcnt_q == '0;
    hs_on  = run_q & (hcnt_q >= HS_BEG) & (hcnt_q < HS_END);
    vs_on  = run_q & (vcnt_q >= VS_BEG) & (vcnt_q < VS_END);

    req_valid_d = run_q & h_vis & v_vis;
    req_x_d     = req_valid_d ? hcnt_q : '0;
    req_y_d     = req_valid_d ? vcnt_q : '0;

    raw_d    = TIM_IDLE;
    raw_d.hs = hs_on ? HS_POL : ~HS_POL;
    raw_d.vs = vs_on ? VS_POL : ~VS_POL;
    raw_d.de = req_valid_d;
    raw_d.ls = run_q & h_zero;
    raw_d.fs = run_q & h_zero & v_zero;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta_q <= 1'b0;
      run_q       <= 1'b0;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      req_valid_q <= 1'b0;
      req_x_q     <= '0;
      req_y_q     <= '0;
      raw_q       <= TIM_IDLE;
    end else begin
      lock_meta_q <= lock_meta_d;
      run_q       <= run_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      req_valid_q <= req_valid_d;
      req_x_q     <= req_x_d;
      req_y_q     <= req_y_d;
      raw_q       <= raw_d;
    end
  end

  // aligns sync/enable with data from a fixed-latency pixel source
  vga_delay_line #(
    .W     ($bits(tim_t)),
    .DEPTH (PIPE_DLY)
  ) u_dly (
    .clk     (clk),
    .rst     (rst),
    .din     (raw_q),
    .rst_val (TIM_IDLE),
    .dout    (tim_out)
  );

  assign req_valid   = req_valid_q;
  assign req_x       = req_x_q;
  assign req_y       = req_y_q;
  assign hsync       = tim_out.hs;
  assign vsync       = tim_out.vs;
  assign de          = tim_out.de;
  assign line_start  = tim_out.ls;
  assign frame_start = tim_out.fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: four generator instances (default, PIPE_DLY 0/7 with
// active-high syncs, tiny raster) checked against a position-based model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       rv;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
  } obs_t;

  typedef struct {
    bit run;
    int p;
  } hent_t;

  localparam int DLY [4] = '{2, 0, 7, 1};
  localparam bit POL [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked = 1'b0;

  logic       rv [4];
  logic [9:0] rx [4];
  logic [9:0] ry [4];
  logic       hs [4];
  logic       vs [4];
  logic       de [4];
  logic       ls [4];
  logic       fs [4];

  obs_t o [4];
  obs_t e [4];
  logic [99:0] o_all, e_all;

  hent_t hist [8];
  bit lk1, lk2;
  int pos;

  int n_cmp = 0;
  int n_bad = 0;

  always #20 clk = ~clk;

  vga_timing_gen u_def (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .req_valid(rv[0]), .req_x(rx[0]), .req_y(ry[0]),
    .hsync(hs[0]), .vsync(vs[0]), .de(de[0]),
    .line_start(ls[0]), .frame_start(fs[0])
  );

  vga_timing_gen #(
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(0)
  ) u_d0 (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .req_valid(rv[1]), .req_x(rx[1]), .req_y(ry[1]),
    .hsync(hs[1]), .vsync(vs[1]), .de(de[1]),
    .line_start(ls[1]), .frame_start(fs[1])
  );

  vga_timing_gen #(
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(7)
  ) u_d7 (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .req_valid(rv[2]), .req_x(rx[2]), .req_y(ry[2]),
    .hsync(hs[2]), .vsync(vs[2]), .de(de[2]),
    .line_start(ls[2]), .frame_start(fs[2])
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .PIPE_DLY(1)
  ) u_sm (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .req_valid(rv[3]), .req_x(rx[3]), .req_y(ry[3]),
    .hsync(hs[3]), .vsync(vs[3]), .de(de[3]),
    .line_start(ls[3]), .frame_start(fs[3])
  );

  for (genvar g = 0; g < 4; g++) begin : g_obs
    assign o[g] = {rv[g], rx[g], ry[g], hs[g], vs[g], de[g], ls[g], fs[g]};
  end

  assign o_all = {o[0], o[1], o[2], o[3]};
  assign e_all = {e[0], e[1], e[2], e[3]};

  // expected outputs from the raster position at a given pipeline age
  function automatic obs_t model_out(input int i);
    obs_t r;
    int ha, hf, hw, hb, va, vf, vw, vb;
    int ht, ft, q, x, y, d;
    bit pl;
    if (i == 3) begin
      ha = 8; hf = 2; hw = 3; hb = 3;
      va = 4; vf = 1; vw = 2; vb = 2;
    end else begin
      ha = 640; hf = 16; hw = 96; hb = 48;
      va = 480; vf = 10; vw = 2; vb = 33;
    end
    ht = ha + hf + hw + hb;
    ft = ht * (va + vf + vw + vb);
    d  = DLY[i];
    pl = POL[i];
    r = '0;
    r.hs = ~pl;
    r.vs = ~pl;
    if (hist[0].run) begin
      q = hist[0].p % ft;
      x = q % ht;
      y = q / ht;
      if (x < ha && y < va) begin
        r.rv = 1'b1;
        r.x  = x[9:0];
        r.y  = y[9:0];
      end
    end
    if (hist[d].run) begin
      q = hist[d].p % ft;
      x = q % ht;
      y = q / ht;
      r.de = (x < ha && y < va);
      r.hs = (x >= ha + hf && x < ha + hf + hw) ? pl : ~pl;
      r.vs = (y >= va + vf && y < va + vf + vw) ? pl : ~pl;
      r.ls = (x == 0);
      r.fs = (q == 0);
    end
    return r;
  endfunction

  // pos counts cycles since the lock became visible; hist ages it
  always @(posedge clk) begin
    if (rst) begin
      lk1 = 1'b0;
      lk2 = 1'b0;
      pos = 0;
      for (int i = 0; i < 8; i++) hist[i] = '{run: 1'b0, p: 0};
    end else begin
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0].run = lk2;
      hist[0].p   = pos;
      pos = lk2 ? pos + 1 : 0;
      lk2 = lk1;
      lk1 = pll_locked;
    end
    for (int i = 0; i < 4; i++) e[i] = model_out(i);
  end

  task automatic test_reset();
    obs_t ex;
    rst = 1'b1;
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ex = '0;
      ex.hs = ~POL[i];
      ex.vs = ~POL[i];
      n_cmp++;
      if (o[i] !== ex) begin
        n_bad++;
        $display("FAIL reset_values dut%0d got=%h exp=%h", i, o[i], ex);
      end
    end
  endtask

  task automatic test_startup();
    int f_rv = -1;
    int f_fs = -1;
    int f_de [4] = '{-1, -1, -1, -1};
    logic [19:0] xy = '1;
    pll_locked = 1'b1;
    rst = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      n_cmp++;
      if (o_all !== e_all) begin
        n_bad++;
        $display("FAIL lockstep_startup t=%0t dut=%h ref=%h", $time, o_all, e_all);
      end
      if (f_rv < 0 && rv[0]) begin
        f_rv = c;
        xy = {rx[0], ry[0]};
      end
      if (f_fs < 0 && fs[0]) f_fs = c;
      for (int i = 0; i < 4; i++) if (f_de[i] < 0 && de[i]) f_de[i] = c;
    end
    n_cmp++;
    if (f_rv != 3) begin n_bad++; $display("FAIL startup_req got=%0d exp=3", f_rv); end
    n_cmp++;
    if (xy !== 20'd0) begin n_bad++; $display("FAIL startup_xy got=%h exp=0", xy); end
    n_cmp++;
    if (f_de[0] != 5) begin n_bad++; $display("FAIL startup_de got=%0d exp=5", f_de[0]); end
    n_cmp++;
    if (f_fs != 5) begin n_bad++; $display("FAIL startup_fs got=%0d exp=5", f_fs); end
    n_cmp++;
    if (f_de[1] != 3) begin n_bad++; $display("FAIL sweep_de_d0 got=%0d exp=3", f_de[1]); end
    n_cmp++;
    if (f_de[2] != 10) begin n_bad++; $display("FAIL sweep_de_d7 got=%0d exp=10", f_de[2]); end
    n_cmp++;
    if (f_de[3] != 4) begin n_bad++; $display("FAIL small_de_d1 got=%0d exp=4", f_de[3]); end
  endtask

  task automatic test_line_timing();
    int k = 0;
    int de_c = 0, hs_c = 0, hs_first = -1, hs0_c = 0, hs7_c = 0, ls_c = 0;
    int skip = $urandom_range(1, 400);
    for (int c = 0; c < skip; c++) begin
      @(negedge clk);
      n_cmp++;
      if (o_all !== e_all) begin
        n_bad++;
        $display("FAIL lockstep_line t=%0t dut=%h ref=%h", $time, o_all, e_all);
      end
    end
    while (!ls[0] && k < 1000) begin
      @(negedge clk);
      k++;
      n_cmp++;
      if (o_all !== e_all) begin
        n_bad++;
        $display("FAIL lockstep_line t=%0t dut=%h ref=%h", $time, o_all, e_all);
      end
    end
    n_cmp++;
    if (ls[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL line_wait got=timeout exp=line_start");
      return;
    end
    for (int off = 0; off < 800; off++) begin
      if (de[0]) de_c++;
      if (ls[0]) ls_c++;
      if (hs[1]) hs0_c++;
      if (hs[2]) hs7_c++;
      if (!hs[0]) begin
        hs_c++;
        if (hs_first < 0) hs_first = off;
      end
      @(negedge clk);
      n_cmp++;
      if (o_all !== e_all) begin
        n_bad++;
        $display("FAIL lockstep_line t=%0t dut=%h ref=%h", $time, o_all, e_all);
      end
    end
    n_cmp++;
    if (de_c != 640) begin n_bad++; $display("FAIL line_de got=%0d exp=640", de_c); end
    n_cmp++;
    if (hs_c != 96) begin n_bad++; $display("FAIL line_hs_width got=%0d exp=96", hs_c); end
    n_cmp++;
    if (hs_first != 656) begin n_bad++; $display("FAIL line_hs_start got=%0d exp=656", hs_first); end
    n_cmp++;
    if (hs0_c != 96) begin n_bad++; $display("FAIL sweep_hs_d0 got=%0d exp=96", hs0_c); end
    n_cmp++;
    if (hs7_c != 96) begin n_bad++; $display("FAIL sweep_hs_d7 got=%0d exp=96", hs7_c); end
    n_cmp++;
    if (ls_c != 1 || ls[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL line_period got=%0d/%b exp=1/1", ls_c, ls[0]);
    end
  endtask

  task automatic test_frame_small();
    int k = 0;
    int fs_c = 0, de_c = 0, vs_c = 0, vs_first = -1;
    logic [19:0] last_xy = '1;
    logic [19:0] wrap_xy = '1;
    logic [19:0] exp_wrap;
    exp_wrap = {10'd7, 10'd3};
    while (!fs[3] && k < 300) begin
      @(negedge clk);
      k++;
      n_cmp++;
      if (o_all !== e_all) begin
        n_bad++;
        $display("FAIL lockstep_frame t=%0t dut=%h ref=%h", $time, o_all, e_all);
      end
    end
    n_cmp++;
    if (fs[3] !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_wait got=timeout exp=frame_start");
      return;
    end
    for (int off = 0; off < 432; off++) begin
      if (fs[3]) fs_c++;
      if (de[3]) de_c++;
      if (!vs[3]) begin
        vs_c++;
        if (vs_first < 0) vs_first = off;
      end
      if (rv[3]) begin
        if (rx[3] == 10'd0 && ry[3] == 10'd0) wrap_xy = last_xy;
        last_xy = {rx[3], ry[3]};
      end
      @(negedge clk);
      n_cmp++;
      if (o_all !== e_all) begin
        n_bad++;
        $display("FAIL lockstep_frame t=%0t dut=%h ref=%h", $time, o_all, e_all);
      end
    end
    n_cmp++;
    if (fs_c != 3 || fs[3] !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_period got=%0d/%b exp=3/1", fs_c, fs[3]);
    end
    n_cmp++;
    if (de_c != 96) begin n_bad++; $display("FAIL frame_de got=%0d exp=96", de_c); end
    n_cmp++;
    if (vs_c != 96) begin n_bad++; $display("FAIL frame_vs_width got=%0d exp=96", vs_c); end
    n_cmp++;
    if (vs_first != 80) begin n_bad++; $display("FAIL frame_vs_start got=%0d exp=80", vs_first); end
    n_cmp++;
    if (wrap_xy !== exp_wrap) begin
      n_bad++;
      $display("FAIL frame_last_req got=%h exp=%h", wrap_xy, exp_wrap);
    end
  endtask

  task automatic test_lock_loss();
    int k = 0;
    int xt = $urandom_range(20, 600);
    int hold = $urandom_range(12, 20);
    int f_low = -1, f_rv = -1, f_fs = -1, f_de7 = -1;
    logic [19:0] xy = '1;
    obs_t ex;
    while (!(rv[0] && rx[0] == 10'(xt)) && k < 2000) begin
      @(negedge clk);
      k++;
      n_cmp++;
      if (o_all !== e_all) begin
        n_bad++;
        $display("FAIL lockstep_lock t=%0t dut=%h ref=%h", $time, o_all, e_all);
      end
    end
    n_cmp++;
    if (!(rv[0] && rx[0] == 10'(xt))) begin
      n_bad++;
      $display("FAIL lock_wait got=timeout exp=x%0d", xt);
      return;
    end
    pll_locked = 1'b0;
    for (int c = 1; c <= hold; c++) begin
      @(negedge clk);
      n_cmp++;
      if (o_all !== e_all) begin
        n_bad++;
        $display("FAIL lockstep_lock t=%0t dut=%h ref=%h", $time, o_all, e_all);
      end
      if (f_low < 0 && !rv[0]) f_low = c;
    end
    n_cmp++;
    if (f_low != 3) begin n_bad++; $display("FAIL lock_drop got=%0d exp=3", f_low); end
    for (int i = 0; i < 4; i++) begin
      ex = '0;
      ex.hs = ~POL[i];
      ex.vs = ~POL[i];
      n_cmp++;
      if (o[i] !== ex) begin
        n_bad++;
        $display("FAIL lock_drained dut%0d got=%h exp=%h", i, o[i], ex);
      end
    end
    pll_locked = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      n_cmp++;
      if (o_all !== e_all) begin
        n_bad++;
        $display("FAIL lockstep_relock t=%0t dut=%h ref=%h", $time, o_all, e_all);
      end
      if (f_rv < 0 && rv[0]) begin
        f_rv = c;
        xy = {rx[0], ry[0]};
      end
      if (f_fs < 0 && fs[0]) f_fs = c;
      if (f_de7 < 0 && de[2]) f_de7 = c;
    end
    n_cmp++;
    if (f_rv != 3 || xy !== 20'd0) begin
      n_bad++;
      $display("FAIL relock_req got=%0d/%h exp=3/0", f_rv, xy);
    end
    n_cmp++;
    if (f_fs != 5) begin n_bad++; $display("FAIL relock_fs got=%0d exp=5", f_fs); end
    n_cmp++;
    if (f_de7 != 10) begin n_bad++; $display("FAIL relock_de_d7 got=%0d exp=10", f_de7); end
  endtask

  task automatic test_mid_reset();
    int wait_c = $urandom_range(100, 3000);
    int f_rv = -1, f_fs = -1;
    obs_t ex;
    for (int c = 0; c < wait_c; c++) begin
      @(negedge clk);
      n_cmp++;
      if (o_all !== e_all) begin
        n_bad++;
        $display("FAIL lockstep_rst t=%0t dut=%h ref=%h", $time, o_all, e_all);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ex = '0;
      ex.hs = ~POL[i];
      ex.vs = ~POL[i];
      n_cmp++;
      if (o[i] !== ex) begin
        n_bad++;
        $display("FAIL midrst_values dut%0d got=%h exp=%h", i, o[i], ex);
      end
    end
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if (o_all !== e_all) begin
        n_bad++;
        $display("FAIL lockstep_rst t=%0t dut=%h ref=%h", $time, o_all, e_all);
      end
      if (f_rv < 0 && rv[0]) f_rv = c;
      if (f_fs < 0 && fs[0]) f_fs = c;
    end
    n_cmp++;
    if (f_rv != 3) begin n_bad++; $display("FAIL midrst_req got=%0d exp=3", f_rv); end
    n_cmp++;
    if (f_fs != 5) begin n_bad++; $display("FAIL midrst_fs got=%0d exp=5", f_fs); end
  endtask

  task automatic test_back_to_back();
    int len;
    for (int it = 0; it < 40; it++) begin
      pll_locked = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 15) == 0);
      len = $urandom_range(1, 60);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (o_all !== e_all) begin
          n_bad++;
          $display("FAIL lockstep_b2b t=%0t dut=%h ref=%h", $time, o_all, e_all);
        end
      end
    end
    pll_locked = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      n_cmp++;
      if (o_all !== e_all) begin
        n_bad++;
        $display("FAIL lockstep_b2b t=%0t dut=%h ref=%h", $time, o_all, e_all);
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_line_timing();
    test_frame_small();
    test_lock_loss();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
